// File: rtl/res_hex_formatter_pkg.sv
// rtl/res_hex_formatter_pkg.sv - shared calculator codes, ASCII constants and formatter FSM encoding
package res_hex_formatter_pkg;

    // Data type codes shared with the parser and ALU
    localparam logic [3:0] DTYPE_SIGNED   = 4'h1;
    localparam logic [3:0] DTYPE_UNSIGNED = 4'h2;

    // ASCII control and punctuation bytes
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    // Formatter FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SIGN  = 3'd1;
    localparam logic [2:0] ST_DIGIT = 3'd2;
    localparam logic [2:0] ST_CR    = 3'd3;
    localparam logic [2:0] ST_LF    = 3'd4;

    // Index of the most significant nonzero nibble among the low ndigits
    // nibbles; 0 when all of them are zero so one digit is always printed.
    function automatic logic [2:0] top_nibble(input logic [31:0] mag, input int ndigits);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < ndigits && mag[4*i +: 4] != 4'h0) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/res_hex_formatter_nib2ascii.sv
// rtl/res_hex_formatter_nib2ascii.sv - combinational nibble to uppercase ASCII hex digit
//
// Ports:
//   nib_i   [3:0]  nibble value 0x0..0xF
//   ascii_o [7:0]  '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
module res_hex_formatter_nib2ascii (
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    // 0xA + 0x37 = 0x41 ('A')
    assign ascii_o = (nib_i < 4'd10) ? {4'h3, nib_i} : (8'h37 + {4'h0, nib_i});

endmodule

// File: rtl/res_hex_formatter.sv
// rtl/res_hex_formatter.sv - serialises ALU results as ASCII hex lines toward the UART transmitter
//
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   alu_done        one-cycle pulse qualifying calc_res/dtype
//   calc_res [31:0] ALU result
//   dtype    [3:0]  data type (signed / unsigned / other = unsigned)
//   tx_ready        UART TX can accept a byte
//   tx_valid        tx_data holds a byte to send
//   tx_data  [7:0]  ASCII byte
//   busy            a result is being formatted/sent
//   fmt_done        one-cycle pulse the cycle after the final byte is accepted
//   overrun         one-cycle pulse when alu_done arrives while busy
module res_hex_formatter
    import res_hex_formatter_pkg::*;
#(
    parameter int NDIGITS     = 8,
    parameter int LZ_SUPPRESS = 0,
    parameter int EOL_EN      = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        alu_done,
    input  logic [31:0] calc_res,
    input  logic [3:0]  dtype,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        fmt_done,
    output logic        overrun
);

    localparam logic [2:0] IDX_TOP = 3'(NDIGITS - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [2:0]  idx_q, idx_d;
    logic        fmt_done_q, fmt_done_d;

    logic        neg_in;
    logic [31:0] mag_in;
    logic        accept;
    logic [3:0]  cur_nib;
    logic [7:0]  digit_ascii;

    assign neg_in = (dtype == DTYPE_SIGNED) && calc_res[31];
    assign mag_in = neg_in ? (~calc_res + 32'd1) : calc_res;

    assign tx_valid = (state_q != ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign fmt_done = fmt_done_q;
    // A new result while a line is in flight (including its final-accept
    // cycle) is dropped; the FSM only latches in IDLE.
    assign overrun  = alu_done && busy;

    assign cur_nib = mag_q[{idx_q, 2'b00} +: 4];

    res_hex_formatter_nib2ascii u_nib2ascii (
        .nib_i   (cur_nib),
        .ascii_o (digit_ascii)
    );

    // tx_data depends only on registered state, so it cannot move while
    // a byte is stalled.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            ST_SIGN:  tx_data = CH_MINUS;
            ST_DIGIT: tx_data = digit_ascii;
            ST_CR:    tx_data = CH_CR;
            ST_LF:    tx_data = CH_LF;
            default:  tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        idx_d      = idx_q;
        fmt_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (alu_done) begin
                    mag_d   = mag_in;
                    // Leading-zero skip is resolved here so DIGIT starts
                    // on the first printed nibble with no bubble.
                    idx_d   = (LZ_SUPPRESS != 0) ? top_nibble(mag_in, NDIGITS) : IDX_TOP;
                    state_d = neg_in ? ST_SIGN : ST_DIGIT;
                end
            end
            ST_SIGN: begin
                if (accept) state_d = ST_DIGIT;
            end
            ST_DIGIT: begin
                if (accept) begin
                    if (idx_q == 3'd0) begin
                        if (EOL_EN != 0) begin
                            state_d = ST_CR;
                        end else begin
                            state_d    = ST_IDLE;
                            fmt_done_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
            end
            ST_CR: begin
                if (accept) state_d = ST_LF;
            end
            ST_LF: begin
                if (accept) begin
                    state_d    = ST_IDLE;
                    fmt_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            mag_q      <= 32'd0;
            idx_q      <= 3'd0;
            fmt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            idx_q      <= idx_d;
            fmt_done_q <= fmt_done_d;
        end
    end

endmodule

// File: tb/tb_res_hex_formatter.sv
// tb/tb_res_hex_formatter.sv - table-driven bench for res_hex_formatter
module tb_res_hex_formatter;

    logic        clk;
    logic        n_rst;
    logic        ad0, ad1;
    logic [31:0] calc_res;
    logic [3:0]  dtype;
    logic        tx_ready;
    logic        tv0, tv1, bz0, bz1, fd0, fd1, ov0, ov1;
    logic [7:0]  td0, td1;

    int nvec = 0;
    int nmis = 0;
    bit sel  = 1'b0;

    logic       cur_v, cur_bz, cur_fd, cur_ov;
    logic [7:0] cur_d;
    assign cur_v  = sel ? tv1 : tv0;
    assign cur_bz = sel ? bz1 : bz0;
    assign cur_fd = sel ? fd1 : fd0;
    assign cur_ov = sel ? ov1 : ov0;
    assign cur_d  = sel ? td1 : td0;

    res_hex_formatter #(.NDIGITS(8), .LZ_SUPPRESS(0), .EOL_EN(1)) dut0 (
        .clk(clk), .n_rst(n_rst), .alu_done(ad0), .calc_res(calc_res), .dtype(dtype),
        .tx_ready(tx_ready), .tx_valid(tv0), .tx_data(td0), .busy(bz0),
        .fmt_done(fd0), .overrun(ov0)
    );

    res_hex_formatter #(.NDIGITS(8), .LZ_SUPPRESS(1), .EOL_EN(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .alu_done(ad1), .calc_res(calc_res), .dtype(dtype),
        .tx_ready(tx_ready), .tx_valid(tv1), .tx_data(td1), .busy(bz1),
        .fmt_done(fd1), .overrun(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  dt;
        bit          lz;
        int          n;
        logic [87:0] ebytes;   // right-aligned, first byte most significant
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one result on the selected DUT and collects its bytes. ovr_at
    // injects a second alu_done in that stream cycle (-1 = none). Returns at
    // posedge+1 of the cycle after fmt_done.
    task automatic run_line(input bit s, input logic [31:0] res, input logic [3:0] dt,
                            input int n, input logic [87:0] ebytes, input bit stall,
                            input int ovr_at, input string tag);
        int          got;
        int          cyc;
        bit          hold;
        logic [7:0]  held;
        sel      = s;
        calc_res = res;
        dtype    = dt;
        tx_ready = 1'b1;
        if (s) ad1 = 1'b1; else ad0 = 1'b1;
        @(negedge clk);
        chk({tag, " idle_before_first"}, {31'd0, cur_v}, 32'd0);
        chk({tag, " no_overrun_when_idle"}, {31'd0, cur_ov}, 32'd0);
        chk({tag, " fmt_done_low"}, {31'd0, cur_fd}, 32'd0);
        step();
        ad0 = 1'b0;
        ad1 = 1'b0;
        got  = 0;
        cyc  = 0;
        hold = 1'b0;
        held = 8'h00;
        while (got < n && cyc < 200) begin
            tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == ovr_at) begin
                if (s) ad1 = 1'b1; else ad0 = 1'b1;
                calc_res = 32'h12345678;
            end
            @(negedge clk);
            if (cyc == 0) begin
                chk({tag, " first_byte_latency"}, {31'd0, cur_v}, 32'd1);
                chk({tag, " busy"}, {31'd0, cur_bz}, 32'd1);
            end
            if (cyc == ovr_at)     chk({tag, " overrun_pulse"}, {31'd0, cur_ov}, 32'd1);
            if (cyc == ovr_at + 1) chk({tag, " overrun_clear"}, {31'd0, cur_ov}, 32'd0);
            if (hold) chk($sformatf("%s stable_byte%0d", tag, got), {24'd0, cur_d}, {24'd0, held});
            if (cur_v && tx_ready) begin
                chk($sformatf("%s byte%0d", tag, got), {24'd0, cur_d},
                    {24'd0, ebytes[8*(n-1-got) +: 8]});
                got++;
            end
            hold = cur_v && !tx_ready;
            held = cur_d;
            step();
            ad0 = 1'b0;
            ad1 = 1'b0;
            cyc++;
        end
        if (got < n) chk({tag, " byte_count_timeout"}, got, n);
        @(negedge clk);
        chk({tag, " fmt_done_pulse"}, {31'd0, cur_fd}, 32'd1);
        chk({tag, " no_extra_byte"}, {31'd0, cur_v}, 32'd0);
        chk({tag, " busy_cleared"}, {31'd0, cur_bz}, 32'd0);
        chk({tag, " overrun_end"}, {31'd0, cur_ov}, 32'd0);
        step();
    endtask

    initial begin
        n_rst    = 1'b0;
        ad0      = 1'b0;
        ad1      = 1'b0;
        calc_res = 32'd0;
        dtype    = 4'h2;
        tx_ready = 1'b1;

        tbl[0]  = '{32'h0000ABCD, 4'h2, 1'b0, 10, 88'h30303030414243440D0A};
        tbl[1]  = '{32'hFFFFFFFF, 4'h1, 1'b0, 11, 88'h2D30303030303030310D0A};
        tbl[2]  = '{32'hFFFFFFFF, 4'h2, 1'b0, 10, 88'h46464646464646460D0A};
        tbl[3]  = '{32'h80000000, 4'h1, 1'b0, 11, 88'h2D38303030303030300D0A};
        tbl[4]  = '{32'h00000005, 4'h1, 1'b0, 10, 88'h30303030303030350D0A};
        tbl[5]  = '{32'hFFFFFF85, 4'h1, 1'b0, 11, 88'h2D30303030303037420D0A};
        tbl[6]  = '{32'h12345678, 4'h7, 1'b0, 10, 88'h31323334353637380D0A};
        tbl[7]  = '{32'h00000000, 4'h2, 1'b0, 10, 88'h30303030303030300D0A};
        tbl[8]  = '{32'h00000000, 4'h2, 1'b1, 3,  88'h300D0A};
        tbl[9]  = '{32'h00000F00, 4'h2, 1'b1, 5,  88'h4630300D0A};
        tbl[10] = '{32'hFFFFFFF8, 4'h1, 1'b1, 4,  88'h2D380D0A};
        tbl[11] = '{32'h80000000, 4'h2, 1'b1, 10, 88'h38303030303030300D0A};
        tbl[12] = '{32'h00000010, 4'h1, 1'b1, 4,  88'h31300D0A};

        #2;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            chk($sformatf("reset tx_valid dut%0d", d), {31'd0, cur_v}, 32'd0);
            chk($sformatf("reset tx_data dut%0d", d), {24'd0, cur_d}, 32'd0);
            chk($sformatf("reset busy dut%0d", d), {31'd0, cur_bz}, 32'd0);
            chk($sformatf("reset fmt_done dut%0d", d), {31'd0, cur_fd}, 32'd0);
        end
        step();
        n_rst = 1'b1;
        step();

        for (int i = 0; i < 13; i++)
            run_line(tbl[i].lz, tbl[i].res, tbl[i].dt, tbl[i].n, tbl[i].ebytes, 1'b0, -1,
                     $sformatf("vec%0d", i));
        for (int i = 0; i < 13; i++)
            run_line(tbl[i].lz, tbl[i].res, tbl[i].dt, tbl[i].n, tbl[i].ebytes, 1'b1, -1,
                     $sformatf("stall_vec%0d", i));

        // Overrun mid-stream, then a result one cycle after fmt_done
        run_line(1'b0, 32'h0000ABCD, 4'h2, 10, 88'h30303030414243440D0A, 1'b0, 4, "ovr_mid");
        run_line(1'b0, 32'h00C0FFEE, 4'h2, 10, 88'h3030433046464545 << 16 | 88'h0D0A, 1'b0, -1,
                 "after_fmt_done");
        // alu_done in the final-accept cycle is dropped too
        run_line(1'b0, 32'h0000ABCD, 4'h2, 10, 88'h30303030414243440D0A, 1'b0, 9, "ovr_finish");
        run_line(1'b1, 32'h00000F00, 4'h2, 5, 88'h4630300D0A, 1'b0, 2, "ovr_lz");

        // Reset after three accepted bytes
        sel      = 1'b0;
        calc_res = 32'hFFFFFFFF;
        dtype    = 4'h1;
        tx_ready = 1'b1;
        ad0      = 1'b1;
        step();
        ad0 = 1'b0;
        repeat (3) step();
        n_rst = 1'b0;
        #1;
        chk("midreset tx_valid", {31'd0, tv0}, 32'd0);
        chk("midreset busy", {31'd0, bz0}, 32'd0);
        chk("midreset tx_data", {24'd0, td0}, 32'd0);
        chk("midreset fmt_done", {31'd0, fd0}, 32'd0);
        repeat (2) step();
        n_rst = 1'b1;
        step();
        run_line(1'b0, 32'h0000ABCD, 4'h2, 10, 88'h30303030414243440D0A, 1'b0, -1, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
